// File: rtl/connect4_pkg.sv
// rtl/connect4_pkg.sv - shared types and constants for the Connect-4 link controller
// Purpose: turn/link FSM state encoding, board dimensions, one-hot helper.
// Ports: none (package).
package connect4_pkg;

  localparam int NUM_COLS  = 7;
  localparam int MAX_MOVES = 42;

  typedef enum logic [2:0] {
    LOCAL    = 3'd0,
    SEND     = 3'd1,
    WAIT_ACK = 3'd2,
    REMOTE   = 3'd3,
    ACK      = 3'd4,
    DONE     = 3'd5,
    ERR      = 3'd6
  } state_t;

  function automatic logic is_onehot7(input logic [NUM_COLS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with rising-edge detect
// Purpose: brings an asynchronous level into the clk domain and flags its rising edge.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high reset
//   din   in  asynchronous level
//   rise  out one-cycle pulse on a synchronised 0->1 transition
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

endmodule

// File: rtl/turn_link_controller.sv
// rtl/turn_link_controller.sv - turn sequencing for a two-board Connect-4 game
// Purpose: accepts local moves, sends them over the serial link, waits for the
//   remote ready handshake, accepts remote moves and issues one drop pulse per move.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   enter, column         local move confirm pulse and one-hot column
//   column_full           per-column full flags from the grid
//   tx_start, tx_col      launch pulse and held column for the serial transmitter
//   tx_done               transmitter finished pulse
//   rx_valid, rx_col      received move pulse and column
//   ready_in, ready_out   asynchronous remote ready line in, local ready line out
//   drop_red, drop_green  one-hot single-cycle drop pulses to the grid
//   P1, P2, my_turn       red/green to move, local player may enter
//   move_count            moves made (0..42)
//   board_full, link_err  game finished, sticky link error
module turn_link_controller
  import connect4_pkg::*;
#(
  parameter bit LOCAL_IS_RED   = 1'b1,
  parameter int ACK_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enter,
  input  logic [NUM_COLS-1:0] column,
  input  logic [NUM_COLS-1:0] column_full,
  output logic                tx_start,
  output logic [NUM_COLS-1:0] tx_col,
  input  logic                tx_done,
  input  logic                rx_valid,
  input  logic [NUM_COLS-1:0] rx_col,
  input  logic                ready_in,
  output logic                ready_out,
  output logic [NUM_COLS-1:0] drop_red,
  output logic [NUM_COLS-1:0] drop_green,
  output logic                P1,
  output logic                P2,
  output logic                my_turn,
  output logic [5:0]          move_count,
  output logic                board_full,
  output logic                link_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam state_t START = LOCAL_IS_RED ? LOCAL : REMOTE;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic [AW-1:0] ack_cnt;
  logic          ready_rise;
  logic          local_ok;
  logic          rx_good;
  logic          remote_ok;
  logic          last_move;

  sync2 u_ready_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ready_in),
    .rise  (ready_rise)
  );

  assign local_ok  = (state == LOCAL) && enter && is_onehot7(column) &&
                     ((column & column_full) == '0);
  assign rx_good   = is_onehot7(rx_col) && ((rx_col & column_full) == '0);
  assign remote_ok = (state == REMOTE) && rx_valid && rx_good;
  assign last_move = (move_count == 6'(MAX_MOVES));

  always_ff @(posedge clk) begin
    if (reset) state <= START;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    my_turn    = 1'b0;
    ready_out  = 1'b0;
    board_full = 1'b0;
    link_err   = 1'b0;
    // Red always opens, so an even move count means red is to move.
    P1         = ~move_count[0];
    P2         = move_count[0];
    case (state)
      LOCAL: begin
        my_turn = 1'b1;
        if (local_ok) state_nx = SEND;
      end
      SEND: begin
        if (tx_done) state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ready_rise)                        state_nx = last_move ? DONE : REMOTE;
        else if (timer == TW'(TIMEOUT_CYCLES)) state_nx = ERR;
      end
      REMOTE: begin
        if (rx_valid) state_nx = rx_good ? ACK : ERR;
      end
      ACK: begin
        ready_out = 1'b1;
        if (ack_cnt == AW'(ACK_CYCLES - 1)) state_nx = last_move ? DONE : LOCAL;
      end
      DONE: begin
        board_full = 1'b1;
        P1         = 1'b0;
        P2         = 1'b0;
      end
      default: begin
        link_err = 1'b1;
        P1       = 1'b0;
        P2       = 1'b0;
      end
    endcase
  end

  // Drop and launch pulses are registered so they appear the cycle after
  // the accepting input and last exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer      <= '0;
      ack_cnt    <= '0;
      move_count <= '0;
      drop_red   <= '0;
      drop_green <= '0;
      tx_start   <= 1'b0;
      tx_col     <= '0;
    end else begin
      timer      <= (state == WAIT_ACK) ? timer + TW'(1) : '0;
      ack_cnt    <= (state == ACK) ? ack_cnt + AW'(1) : '0;
      tx_start   <= local_ok;
      drop_red   <= '0;
      drop_green <= '0;
      if (local_ok) begin
        tx_col     <= column;
        move_count <= move_count + 6'd1;
        if (LOCAL_IS_RED) drop_red   <= column;
        else              drop_green <= column;
      end
      if (remote_ok) begin
        move_count <= move_count + 6'd1;
        if (LOCAL_IS_RED) drop_green <= rx_col;
        else              drop_red   <= rx_col;
      end
    end
  end

endmodule

// File: tb/tb_turn_link_controller.sv
// tb/tb_turn_link_controller.sv - self-checking bench for turn_link_controller
module tb_turn_link_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0;
  logic [6:0] column = '0;
  logic [6:0] column_full = '0;
  logic       tx_done = 1'b0;
  logic       rx_valid = 1'b0;
  logic [6:0] rx_col = '0;
  logic       ready_in = 1'b0;

  logic       a_tx_start, a_ready_out, a_P1, a_P2, a_my_turn, a_board_full, a_link_err;
  logic [6:0] a_tx_col, a_drop_red, a_drop_green;
  logic [5:0] a_move_count;
  logic       b_tx_start, b_ready_out, b_P1, b_P2, b_my_turn, b_board_full, b_link_err;
  logic [6:0] b_tx_col, b_drop_red, b_drop_green;
  logic [5:0] b_move_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  turn_link_controller #(.LOCAL_IS_RED(1'b1), .ACK_CYCLES(4), .TIMEOUT_CYCLES(1023)) dut_a (
    .clk(clk), .reset(reset), .enter(enter), .column(column), .column_full(column_full),
    .tx_start(a_tx_start), .tx_col(a_tx_col), .tx_done(tx_done), .rx_valid(rx_valid),
    .rx_col(rx_col), .ready_in(ready_in), .ready_out(a_ready_out), .drop_red(a_drop_red),
    .drop_green(a_drop_green), .P1(a_P1), .P2(a_P2), .my_turn(a_my_turn),
    .move_count(a_move_count), .board_full(a_board_full), .link_err(a_link_err)
  );

  turn_link_controller #(.LOCAL_IS_RED(1'b0), .ACK_CYCLES(4), .TIMEOUT_CYCLES(1023)) dut_b (
    .clk(clk), .reset(reset), .enter(enter), .column(column), .column_full(column_full),
    .tx_start(b_tx_start), .tx_col(b_tx_col), .tx_done(tx_done), .rx_valid(rx_valid),
    .rx_col(rx_col), .ready_in(ready_in), .ready_out(b_ready_out), .drop_red(b_drop_red),
    .drop_green(b_drop_green), .P1(b_P1), .P2(b_P2), .my_turn(b_my_turn),
    .move_count(b_move_count), .board_full(b_board_full), .link_err(b_link_err)
  );

  typedef struct {
    logic       enter;
    logic [6:0] column;
    logic [6:0] column_full;
    logic       tx_done;
    logic       rx_valid;
    logic [6:0] rx_col;
    logic       ready_in;
    logic [6:0] e_red;
    logic [6:0] e_green;
    logic       e_tx_start;
    logic [6:0] e_tx_col;
    logic       e_my_turn;
    logic       e_ready_out;
    logic [5:0] e_mc;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_turn(input string name);
    int n = 0;
    while (!a_my_turn && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(a_my_turn), 32'd1);
  endtask

  task automatic clear_inputs();
    enter = 1'b0; column = '0; column_full = '0; tx_done = 1'b0;
    rx_valid = 1'b0; rx_col = '0; ready_in = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] acc_drop;
    logic       acc_misc;
    logic [6:0] c;
    logic [6:0] r;

    // in: enter column full tx_done rx_valid rx_col ready | exp: red green tx_start tx_col my_turn ready_out mc
    vecs[0]  = '{1'b1, 7'b0011000, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b0, 7'b0, 7'b0, 1'b0, 7'b0000000, 1'b1, 1'b0, 6'd0};
    vecs[1]  = '{1'b1, 7'b0000100, 7'b0000100, 1'b0, 1'b0, 7'b0000000, 1'b0, 7'b0, 7'b0, 1'b0, 7'b0000000, 1'b1, 1'b0, 6'd0};
    vecs[2]  = '{1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b1, 7'b0000001, 1'b0, 7'b0, 7'b0, 1'b0, 7'b0000000, 1'b1, 1'b0, 6'd0};
    vecs[3]  = '{1'b1, 7'b0001000, 7'b0000000, 1'b0, 1'b1, 7'b0000001, 1'b0, 7'b0001000, 7'b0, 1'b1, 7'b0001000, 1'b0, 1'b0, 6'd1};
    vecs[4]  = '{1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b1, 7'b0000010, 1'b0, 7'b0, 7'b0, 1'b0, 7'b0001000, 1'b0, 1'b0, 6'd1};
    vecs[5]  = '{1'b0, 7'b0000000, 7'b0000000, 1'b1, 1'b0, 7'b0000000, 1'b0, 7'b0, 7'b0, 1'b0, 7'b0001000, 1'b0, 1'b0, 6'd1};
    vecs[6]  = '{1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b1, 7'b0, 7'b0, 1'b0, 7'b0001000, 1'b0, 1'b0, 6'd1};
    vecs[7]  = '{1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b1, 7'b0, 7'b0, 1'b0, 7'b0001000, 1'b0, 1'b0, 6'd1};
    vecs[8]  = '{1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b1, 7'b0, 7'b0, 1'b0, 7'b0001000, 1'b0, 1'b0, 6'd1};
    vecs[9]  = '{1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b1, 7'b0000001, 1'b0, 7'b0, 7'b0000001, 1'b0, 7'b0001000, 1'b0, 1'b1, 6'd2};
    vecs[10] = '{1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b0, 7'b0, 7'b0, 1'b0, 7'b0001000, 1'b0, 1'b1, 6'd2};
    vecs[11] = '{1'b1, 7'b0000010, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b0, 7'b0, 7'b0, 1'b0, 7'b0001000, 1'b0, 1'b1, 6'd2};
    vecs[12] = '{1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b0, 7'b0, 7'b0, 1'b0, 7'b0001000, 1'b0, 1'b1, 6'd2};
    vecs[13] = '{1'b0, 7'b0000000, 7'b0000000, 1'b0, 1'b0, 7'b0000000, 1'b0, 7'b0, 7'b0, 1'b0, 7'b0001000, 1'b1, 1'b0, 6'd2};

    // Reset state
    reset = 1'b1;
    tick();
    check("rst_my_turn", 32'(a_my_turn), 32'd1);
    check("rst_P1", 32'(a_P1), 32'd1);
    check("rst_P2", 32'(a_P2), 32'd0);
    check("rst_mc", 32'(a_move_count), 32'd0);
    check("rst_drops", 32'({a_drop_red, a_drop_green}), 32'd0);
    check("rst_misc", 32'({a_tx_start, a_ready_out, a_board_full, a_link_err}), 32'd0);
    reset = 1'b0;

    // Table-driven handshake round trip
    for (int i = 0; i < 14; i++) begin
      enter = vecs[i].enter; column = vecs[i].column; column_full = vecs[i].column_full;
      tx_done = vecs[i].tx_done; rx_valid = vecs[i].rx_valid; rx_col = vecs[i].rx_col;
      ready_in = vecs[i].ready_in;
      tick();
      check($sformatf("v%0d_red", i), 32'(a_drop_red), 32'(vecs[i].e_red));
      check($sformatf("v%0d_green", i), 32'(a_drop_green), 32'(vecs[i].e_green));
      check($sformatf("v%0d_tx_start", i), 32'(a_tx_start), 32'(vecs[i].e_tx_start));
      check($sformatf("v%0d_tx_col", i), 32'(a_tx_col), 32'(vecs[i].e_tx_col));
      check($sformatf("v%0d_my_turn", i), 32'(a_my_turn), 32'(vecs[i].e_my_turn));
      check($sformatf("v%0d_ready_out", i), 32'(a_ready_out), 32'(vecs[i].e_ready_out));
      check($sformatf("v%0d_mc", i), 32'(a_move_count), 32'(vecs[i].e_mc));
    end
    clear_inputs();
    check("rt_P1", 32'(a_P1), 32'd1);

    // Timeout in WAIT_ACK
    enter = 1'b1; column = 7'b0000001;
    tick();
    clear_inputs();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (1000) tick();
    check("to_not_yet", 32'(a_link_err), 32'd0);
    repeat (30) tick();
    check("to_link_err", 32'(a_link_err), 32'd1);
    check("to_P1P2", 32'({a_P1, a_P2}), 32'd0);
    acc_drop = '0;
    acc_misc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      enter = 1'b1; column = 7'b0000010; rx_valid = 1'b1; rx_col = 7'b0000100;
      tx_done = 1'b1; ready_in = i[0];
      tick();
      acc_drop = acc_drop | a_drop_red | a_drop_green;
      acc_misc = acc_misc | a_tx_start | a_ready_out;
    end
    clear_inputs();
    check("err_sticky", 32'(a_link_err), 32'd1);
    check("err_no_drops", 32'(acc_drop), 32'd0);
    check("err_no_tx_ready", 32'(acc_misc), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("err_rst_link_err", 32'(a_link_err), 32'd0);
    check("err_rst_mc", 32'(a_move_count), 32'd0);
    check("err_rst_my_turn", 32'(a_my_turn), 32'd1);
    check("err_rst_outs", 32'({a_tx_start, a_ready_out, a_drop_red, a_drop_green, a_tx_col}), 32'd0);

    // Full 42-move game
    for (int m = 0; m < 21; m++) begin
      c = 7'b0000001 << (m % 7);
      r = 7'b0000001 << ((m + 3) % 7);
      wait_turn($sformatf("g%0d_turn", m));
      enter = 1'b1; column = c;
      tick();
      enter = 1'b0;
      check($sformatf("g%0d_red", m), 32'(a_drop_red), 32'(c));
      check($sformatf("g%0d_mc_l", m), 32'(a_move_count), 32'(2 * m + 1));
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      ready_in = 1'b1;
      repeat (3) tick();
      ready_in = 1'b0;
      rx_valid = 1'b1; rx_col = r;
      tick();
      rx_valid = 1'b0;
      check($sformatf("g%0d_green", m), 32'(a_drop_green), 32'(r));
      check($sformatf("g%0d_mc_r", m), 32'(a_move_count), 32'(2 * m + 2));
    end
    repeat (6) tick();
    check("done_board_full", 32'(a_board_full), 32'd1);
    check("done_mc", 32'(a_move_count), 32'd42);
    check("done_flags", 32'({a_P1, a_P2, a_my_turn, a_ready_out}), 32'd0);
    acc_drop = '0;
    acc_misc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      enter = 1'b1; column = 7'b0001000; rx_valid = 1'b1; rx_col = 7'b0000010;
      ready_in = i[0];
      tick();
      acc_drop = acc_drop | a_drop_red | a_drop_green;
      acc_misc = acc_misc | a_tx_start;
    end
    clear_inputs();
    check("done_no_drops", 32'(acc_drop), 32'd0);
    check("done_no_tx", 32'(acc_misc), 32'd0);
    check("done_mc_hold", 32'(a_move_count), 32'd42);

    // Local plays green
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("b_rst_my_turn", 32'(b_my_turn), 32'd0);
    check("b_rst_P1P2", 32'({b_P1, b_P2}), 32'b10);
    check("b_rst_flags", 32'({b_board_full, b_link_err}), 32'd0);
    rx_valid = 1'b1; rx_col = 7'b0000100;
    tick();
    rx_valid = 1'b0;
    check("b_remote_red", 32'(b_drop_red), 32'h04);
    check("b_remote_green", 32'(b_drop_green), 32'd0);
    check("b_ready_out", 32'(b_ready_out), 32'd1);
    check("b_mc1", 32'(b_move_count), 32'd1);
    repeat (4) tick();
    check("b_my_turn", 32'(b_my_turn), 32'd1);
    check("b_P1P2_green", 32'({b_P1, b_P2}), 32'b01);
    enter = 1'b1; column = 7'b0100000;
    tick();
    enter = 1'b0;
    check("b_local_green", 32'(b_drop_green), 32'h20);
    check("b_local_red", 32'(b_drop_red), 32'd0);
    check("b_tx", 32'({b_tx_start, b_tx_col}), 32'({1'b1, 7'b0100000}));
    check("b_mc2", 32'(b_move_count), 32'd2);

    // Bad remote column drives ERR
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rx_valid = 1'b1; rx_col = 7'b0000011;
    tick();
    rx_valid = 1'b0;
    check("b_bad_rx_err", 32'(b_link_err), 32'd1);
    check("b_bad_rx_drops", 32'({b_drop_red, b_drop_green}), 32'd0);
    check("b_bad_rx_P", 32'({b_P1, b_P2, b_ready_out}), 32'd0);
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/turn_link_controller.md
Name: turn_link_controller

Overview:
- Sequences one Connect-4 game across the two-board GPIO link.
- Decides whose turn it is and accepts the local move from `native_board_input`.
- Launches the local move on `serial_out`, waits for the remote board's ready handshake, then accepts the remote move from `serial_in`.
- Issues exactly one one-hot drop pulse per move to `grid`, in the correct colour. Replaces `change_Player` and the ad-hoc enter routing at top level.

Parameters:
- LOCAL_IS_RED, 1, 1 = local board plays red and moves first; 0 = local plays green and waits for the remote first.
- ACK_CYCLES, 4, number of cycles `ready_out` is held high after a remote move is accepted.
- TIMEOUT_CYCLES, 1023, maximum cycles in WAIT_ACK before a link error.

Ports:
- clk  in  1  system clock (all logic on rising edge)
- reset  in  1  synchronous, active-high reset
- enter  in  1  one-cycle pulse, local player confirms move
- column  in  7  local column select, one-hot required
- column_full  in  7  per-column full flags from `grid`
- tx_start  out  1  one-cycle pulse to `serial_out`
- tx_col  out  7  column sent; held stable from tx_start until tx_done
- tx_done  in  1  one-cycle pulse, frame fully shifted out
- rx_valid  in  1  one-cycle pulse, `serial_in` frame complete
- rx_col  in  7  received column, valid with rx_valid
- ready_in  in  1  remote ready line, asynchronous
- ready_out  out  1  ready line to remote
- drop_red  out  7  one-hot, one-cycle drop pulse to `grid`
- drop_green  out  7  one-hot, one-cycle drop pulse to `grid`
- P1  out  1  red to move
- P2  out  1  green to move
- my_turn  out  1  local player may enter a move
- move_count  out  6  moves made, 0..42
- board_full  out  1  game ended, 42 moves made
- link_err  out  1  sticky error flag

Behaviour:
- **ready_in synchroniser.** Two-flop synchroniser on ready_in; rising edge detected on the synchronised value. Latency is 2–3 cycles.
- **States** (LOCAL_IS_RED=1 starts in LOCAL; LOCAL_IS_RED=0 starts in REMOTE):
  - LOCAL: my_turn=1. On enter with column one-hot and column&column_full==0:
    - next cycle, drop pulse in the local colour = column;
    - tx_start=1, tx_col=column;
    - move_count+1;
    - go to SEND.
    An invalid or full column is ignored and the state stays LOCAL.
  - SEND: wait for tx_done, then go to WAIT_ACK and clear the timeout counter.
  - WAIT_ACK: on a synchronised ready_in rising edge, go to DONE if move_count==42, else REMOTE. Counter reaching TIMEOUT_CYCLES goes to ERR.
  - REMOTE: no timeout. On rx_valid with rx_col one-hot and not full:
    - next cycle, drop pulse in the remote colour;
    - move_count+1;
    - go to ACK.
    On rx_valid with an invalid or full rx_col, go to ERR.
  - ACK: ready_out=1 for exactly ACK_CYCLES cycles, then DONE if move_count==42, else LOCAL.
  - DONE: board_full=1; all inputs ignored until reset.
  - ERR: link_err=1; drops, tx_start and ready_out held 0 until reset.
- **P1/P2.** P1 = red to move and P2 = ~P1, except in DONE/ERR where both are 0. Local colour is red if LOCAL_IS_RED, else green.
- **Ignored inputs.** enter outside LOCAL and rx_valid outside REMOTE are ignored. If both arrive in the same cycle, only the one legal for the current state acts.
- **Exclusivity.** drop_red and drop_green are never both nonzero. Each accepted move produces exactly one single-cycle pulse.
- **Reset values.** On reset (at any time, including mid-frame): all outputs 0, move_count=0, link_err=0, state = start state per LOCAL_IS_RED.

Decomposition:
- Package `connect4_pkg`:
  - state enum (LOCAL, SEND, WAIT_ACK, REMOTE, ACK, DONE, ERR);
  - NUM_COLS=7, MAX_MOVES=42;
  - function `is_onehot7`.
- Sub-module `sync2`: two-flop synchroniser plus rising-edge detect, used for ready_in.

Test Plan:
- LOCAL_IS_RED=1, enter with column=7'b0001000 → next cycle drop_red=7'b0001000 and tx_start=1 for 1 cycle, tx_col=7'b0001000, move_count=1, state SEND.
- After tx_done, ready_in rising → REMOTE within 3 cycles; rx_valid with rx_col=7'b0000001 → drop_green=7'b0000001 for one cycle, ready_out high for exactly 4 cycles, then my_turn=1.
- Invalid local input ignored, no drops and no tx_start in all three cases:
  - enter with column=7'b0011000 (not one-hot);
  - enter with column=7'b0000100 while column_full[2]=1;
  - rx_valid while in LOCAL.
- WAIT_ACK with ready_in held low for 1024 cycles → link_err=1 sticky, P1=P2=0. Then reset=1 for one cycle → all outputs 0, my_turn=1.
- Play 42 alternating valid moves → move_count=42, board_full=1, DONE entered; further enter and rx_valid produce no drop pulses.
- LOCAL_IS_RED=0 → starts in REMOTE with my_turn=0, P1=1. Remote move drops red; the subsequent local move drops green.
